// File: rtl/simmem_row_delay_calc.sv
// Single-bank DRAM row-buffer delay model: accepts one address request, waits its row cost, then releases it.
// Optional hit/miss statistics are built only when SIMMEM_ROW_DELAY_STATS_EN is defined.
module simmem_row_delay_calc #(
  parameter int IidWidth = 5,
  parameter int CntWidth = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [15:0]         req_addr_i,
  input  logic [IidWidth-1:0] req_iid_i,
  input  logic                req_is_write_i,
  output logic                release_valid_o,
  input  logic                release_ready_i,
  output logic [IidWidth-1:0] release_iid_o,
  output logic                release_is_write_o,
  output logic [15:0]         row_hits_o,
  output logic [15:0]         row_misses_o
);

  localparam int AxAddrWidth       = 16;
  localparam int RowBufferLenWidth = 8;
  localparam int RowWidth          = AxAddrWidth - RowBufferLenWidth;

  localparam int RowHitCost     = 10;
  localparam int ActivationCost = 45;
  localparam int PrechargeCost  = 50;

  // Counter is loaded with cost-1 so the release lands exactly cost edges after acceptance.
  localparam logic [CntWidth-1:0] HitLoad    = CntWidth'(RowHitCost - 1);
  localparam logic [CntWidth-1:0] ClosedLoad = CntWidth'(ActivationCost + RowHitCost - 1);
  localparam logic [CntWidth-1:0] MissLoad   = CntWidth'(PrechargeCost + ActivationCost + RowHitCost - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBusy    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic                row_open_reg, row_open_next;
  logic [RowWidth-1:0] open_row_reg, open_row_next;
  logic [IidWidth-1:0] iid_reg, iid_next;
  logic                is_write_reg, is_write_next;

  logic [RowWidth-1:0] req_row;
  logic                accept;
  logic                row_hit;
  logic                unused_col_bits;

  assign req_row         = req_addr_i[AxAddrWidth-1:RowBufferLenWidth];
  assign unused_col_bits = ^req_addr_i[RowBufferLenWidth-1:0];
  assign accept          = req_valid_i && (state_reg == StIdle);
  assign row_hit         = row_open_reg && (open_row_reg == req_row);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    row_open_next = row_open_reg;
    open_row_next = open_row_reg;
    iid_next      = iid_reg;
    is_write_next = is_write_reg;
    case (state_reg)
      StIdle: begin
        if (accept) begin
          if (!row_open_reg) begin
            cnt_next = ClosedLoad;
          end else if (row_hit) begin
            cnt_next = HitLoad;
          end else begin
            cnt_next = MissLoad;
          end
          iid_next      = req_iid_i;
          is_write_next = req_is_write_i;
          open_row_next = req_row;
          row_open_next = 1'b1;
          state_next    = StBusy;
        end
      end
      StBusy: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CntWidth'(1);
        end else begin
          state_next = StRelease;
        end
      end
      StRelease: begin
        if (release_ready_i) begin
          state_next = StIdle;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= StIdle;
      cnt_reg      <= '0;
      row_open_reg <= 1'b0;
      open_row_reg <= '0;
      iid_reg      <= '0;
      is_write_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      row_open_reg <= row_open_next;
      open_row_reg <= open_row_next;
      iid_reg      <= iid_next;
      is_write_reg <= is_write_next;
    end
  end

  assign req_ready_o        = (state_reg == StIdle);
  assign release_valid_o    = (state_reg == StRelease);
  assign release_iid_o      = iid_reg;
  assign release_is_write_o = is_write_reg;

`ifdef SIMMEM_ROW_DELAY_STATS_EN
  logic [15:0] hits_reg, misses_reg;

  // Closed-bank activations count as misses alongside true row conflicts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else if (accept) begin
      if (row_hit) begin
        if (hits_reg != 16'hFFFF) hits_reg <= hits_reg + 16'd1;
      end else begin
        if (misses_reg != 16'hFFFF) misses_reg <= misses_reg + 16'd1;
      end
    end
  end

  assign row_hits_o   = hits_reg;
  assign row_misses_o = misses_reg;
`else
  assign row_hits_o   = '0;
  assign row_misses_o = '0;
`endif

endmodule

// File: tb/tb_simmem_row_delay_calc.sv
// Directed bench for simmem_row_delay_calc: vector table of requests plus backpressure and reset sequences.
module tb_simmem_row_delay_calc;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_addr_i = '0;
  logic [4:0]  req_iid_i = '0;
  logic        req_is_write_i = 1'b0;
  logic        release_valid_o;
  logic        release_ready_i = 1'b0;
  logic [4:0]  release_iid_o;
  logic        release_is_write_o;
  logic [15:0] row_hits_o;
  logic [15:0] row_misses_o;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  simmem_row_delay_calc dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_iid_i          (req_iid_i),
    .req_is_write_i     (req_is_write_i),
    .release_valid_o    (release_valid_o),
    .release_ready_i    (release_ready_i),
    .release_iid_o      (release_iid_o),
    .release_is_write_o (release_is_write_o),
    .row_hits_o         (row_hits_o),
    .row_misses_o       (row_misses_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] addr;
    logic [4:0]  iid;
    logic        is_write;
    int          cost;
    bit          hit;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef SIMMEM_ROW_DELAY_STATS_EN
    check({tag, "_hits"}, int'(row_hits_o), exp_hits);
    check({tag, "_misses"}, int'(row_misses_o), exp_misses);
`else
    check({tag, "_hits_tied"}, int'(row_hits_o), 0);
    check({tag, "_misses_tied"}, int'(row_misses_o), 0);
`endif
  endtask

  // Present one request at a negedge, accept it, then count edges until release_valid_o rises.
  task automatic issue(input logic [15:0] a, input logic [4:0] id, input logic w, input bit hit,
                       output int lat);
    @(negedge clk_i);
    check("req_ready_idle", int'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_addr_i = a;
    req_iid_i = id;
    req_is_write_i = w;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    if (hit) exp_hits++; else exp_misses++;
    check("req_ready_busy", int'(req_ready_o), 0);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (release_valid_o) break;
    end
    if (lat >= 300) check("release_timeout", 0, 1);
  endtask

  // Called at a negedge with release_valid_o high; completes the handshake.
  task automatic do_release();
    release_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    release_ready_i = 1'b0;
    check("release_done_valid", int'(release_valid_o), 0);
    check("release_done_ready", int'(req_ready_o), 1);
  endtask

  initial begin
    int lat;
    bit saw_release;

    vecs[0] = '{16'h1234, 5'd3, 1'b0, 55, 1'b0};
    vecs[1] = '{16'h12FF, 5'd7, 1'b1, 10, 1'b1};
    vecs[2] = '{16'h5600, 5'd1, 1'b0, 105, 1'b0};
    vecs[3] = '{16'h56AB, 5'd2, 1'b1, 10, 1'b1};
    vecs[4] = '{16'h1200, 5'd4, 1'b0, 105, 1'b0};
    vecs[5] = '{16'h0000, 5'd5, 1'b1, 105, 1'b0};
    vecs[6] = '{16'h00FF, 5'd6, 1'b0, 10, 1'b1};

    // Reset values
    #12;
    check("rst_req_ready", int'(req_ready_o), 1);
    check("rst_release_valid", int'(release_valid_o), 0);
    check("rst_release_iid", int'(release_iid_o), 0);
    check("rst_release_is_write", int'(release_is_write_o), 0);
    check_stats("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].addr, vecs[i].iid, vecs[i].is_write, vecs[i].hit, lat);
      $display("vec %0d addr=%h iid=%0d wr=%0b latency=%0d expected=%0d", i, vecs[i].addr,
               vecs[i].iid, vecs[i].is_write, lat, vecs[i].cost);
      check("latency", lat, vecs[i].cost);
      check("release_iid", int'(release_iid_o), int'(vecs[i].iid));
      check("release_is_write", int'(release_is_write_o), int'(vecs[i].is_write));
      do_release();
      check_stats("vec");
    end

    // Backpressure, with a competing request that must not disturb the open row
    issue(16'h00AA, 5'd9, 1'b1, 1'b1, lat);
    check("bp_latency", lat, 10);
    req_valid_i = 1'b1;
    req_addr_i = 16'hAB00;
    req_iid_i = 5'd17;
    req_is_write_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i);
      #1;
      check("bp_valid", int'(release_valid_o), 1);
      check("bp_iid", int'(release_iid_o), 9);
      check("bp_is_write", int'(release_is_write_o), 1);
      check("bp_req_ready", int'(req_ready_o), 0);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    do_release();
    $display("backpressure held 20 cycles, released iid 9");
    issue(16'h0011, 5'd10, 1'b0, 1'b1, lat);
    $display("post-backpressure same-row request latency=%0d expected=10", lat);
    check("row_kept_latency", lat, 10);
    do_release();
    check_stats("bp");

    // Reset 40 cycles into a 105-cycle request
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i = 16'h7700;
    req_iid_i = 5'd12;
    req_is_write_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    check("midrst_req_ready", int'(req_ready_o), 1);
    check("midrst_release_valid", int'(release_valid_o), 0);
    check("midrst_release_iid", int'(release_iid_o), 0);
    check_stats("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    saw_release = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk_i);
      if (release_valid_o) saw_release = 1'b1;
    end
    check("midrst_no_release", int'(saw_release), 0);
    check("midrst_idle_ready", int'(req_ready_o), 1);
    issue(16'h7700, 5'd13, 1'b0, 1'b0, lat);
    $display("post-reset request to row 77 latency=%0d expected=55", lat);
    check("postrst_latency", lat, 55);
    check("postrst_iid", int'(release_iid_o), 13);
    do_release();
    check_stats("postrst");

`ifdef SIMMEM_ROW_DELAY_STATS_EN
    // Saturation of the hit counter
    for (int n = 0; n < 65537; n++) begin
      issue(16'h7701, 5'd1, 1'b0, 1'b1, lat);
      do_release();
    end
    $display("saturation run: hits=%h misses=%h", row_hits_o, row_misses_o);
    check("sat_hits", int'(row_hits_o), 16'hFFFF);
    check("sat_misses", int'(row_misses_o), exp_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simmem_row_delay_calc.md
SIMMEM_ROW_DELAY_CALC -- requirements
Module: simmem_row_delay_calc

Interface
REQ-001 SHALL have parameter IidWidth, default WriteRespBankAddrWidth (5), width of the internal identifier carried with each request.
REQ-002 SHALL have parameter CntWidth, default 7, width of the delay counter; it holds the worst-case cost of 105.
REQ-003 SHALL have port clk_i, input, 1, the single clock. All state is updated on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, 1, an address request is presented.
REQ-006 SHALL have port req_ready_o, output, 1, the block accepts a request.
REQ-007 SHALL have port req_addr_i, input, AxAddrWidth (16), the request byte address.
REQ-008 SHALL have port req_iid_i, input, IidWidth, the internal identifier of the request.
REQ-009 SHALL have port req_is_write_i, input, 1, 1 for a write address request, 0 for a read.
REQ-010 SHALL have port release_valid_o, output, 1, the simulated delay of the current request has elapsed.
REQ-011 SHALL have port release_ready_i, input, 1, the response bank consumes the release.
REQ-012 SHALL have port release_iid_o, output, IidWidth, the identifier being released.
REQ-013 SHALL have port release_is_write_o, output, 1, the direction of the released request.
REQ-014 SHALL have port row_hits_o, output, 16, the row-hit count.
REQ-015 SHALL have port row_misses_o, output, 16, the count of row misses plus activations of a closed bank.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BUSY and RELEASE.
REQ-017 SHALL drive req_ready_o = 1 only in IDLE; the request is accepted on an edge where req_valid_i && req_ready_o.
REQ-018 SHALL take the row as req_addr_i[AxAddrWidth-1:RowBufferLenWidth], i.e. the upper 8 bits.
REQ-019 SHALL compute the cost on acceptance from the open-row state:
- no row open: ActivationCost+RowHitCost = 55;
- same row open: RowHitCost = 10;
- different row open: PrechargeCost+ActivationCost+RowHitCost = 105.
REQ-020 SHALL on acceptance:
- load the counter with cost-1;
- latch the iid and is_write;
- set the open row to the request row and set the row-open flag;
- move to BUSY.
REQ-021 SHALL in BUSY decrement the counter each cycle while it is nonzero, and move to RELEASE on the edge where the counter is 0.
REQ-022 SHALL therefore assert release_valid_o exactly cost rising edges after the accepting edge.
REQ-023 SHALL in RELEASE:
- hold release_valid_o = 1, with release_iid_o and release_is_write_o stable, until release_ready_i = 1;
- then return to IDLE.
REQ-024 SHALL keep req_ready_o = 0 in the cycle the release handshakes; there is no same-cycle bypass, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-025 SHALL drive release_iid_o and release_is_write_o from the latched values in all states; they are meaningful only while release_valid_o = 1.
REQ-026 SHALL keep the open row unchanged when req_valid_i is asserted outside IDLE.
REQ-027 SHALL not accept a request whose req_valid_i is deasserted before acceptance; no request state is retained.

Reset
REQ-028 SHALL on rst_ni = 0 immediately force:
- FSM to IDLE, counter to 0, row-open flag to 0 and open row to 0;
- latched iid and is_write to 0;
- row_hits_o and row_misses_o to 0.
REQ-029 SHALL drive these output values in reset: req_ready_o = 1, release_valid_o = 0, release_iid_o = 0, release_is_write_o = 0.
REQ-030 SHALL silently drop a request in BUSY or RELEASE when reset asserts; it is never released.

Configuration
REQ-031 SHALL compile the statistics counters in only when SIMMEM_ROW_DELAY_STATS_EN is defined.
REQ-032 SHALL with SIMMEM_ROW_DELAY_STATS_EN defined, at each acceptance:
- increment row_hits_o for a same-row request;
- otherwise increment row_misses_o;
- saturate both counters at 16'hFFFF.
REQ-033 SHALL with SIMMEM_ROW_DELAY_STATS_EN undefined, tie row_hits_o and row_misses_o to 0 and keep all other behaviour identical.

Verification
REQ-034 SHALL cover cold access: after reset, a request with addr 16'h1234, iid 3, read -> release_valid_o rises 55 edges after acceptance with iid 3 and is_write 0.
REQ-035 SHALL cover a row hit: addr 16'h1234, then addr 16'h12FF, iid 7, write -> the second release comes 10 edges after its acceptance; with stats enabled, hits=1 and misses=1.
REQ-036 SHALL cover a row miss: addr 16'h1234, then addr 16'h5600 -> the second release comes 105 edges after its acceptance.
REQ-037 SHALL cover backpressure: release_ready_i held 0 for 20 cycles in RELEASE -> release_valid_o, release_iid_o and release_is_write_o stay stable, req_ready_o stays 0, and the state returns to IDLE on the edge where ready = 1.
REQ-038 SHALL cover reset mid-operation: rst_ni pulsed low 40 cycles into a 105-cycle request -> no release occurs, req_ready_o = 1, and the next request to the same row costs 55.
REQ-039 SHALL cover saturation: with stats enabled, 65 537 same-row hits -> row_hits_o = 16'hFFFF.
